// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Purpose  : Parallel-in/serial-out stage feeding the serial sequence detector.
//            Define SER_PARITY_EN to append an even-parity bit to every word.
// Revision : 1.0
// ============================================================================
module seq_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_start,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int N_BITS = WIDTH + 1;
`else
  localparam int N_BITS = WIDTH;
`endif
  localparam int                CNT_W      = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] IDX_ONE    = CNT_W'(1);
`ifdef SER_PARITY_EN
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(WIDTH - 1);
`endif
  localparam int                GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0]       GAP_LAST   = 4'(GAP_LAST_I);
  localparam logic [3:0]       GAP_ONE    = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             word_start_q, word_start_d;
  logic             busy_q, busy_d;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_shreg;
  logic [WIDTH-1:0] next_shreg;

  // The register holds only the bits not yet driven; the bit on serial_out has
  // already been shifted out of it.
  assign first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign load_shreg = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
  assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign next_shreg = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = 1'b1;
      ST_SHIFT: in_ready = (GAP_CYCLES == 0) && (idx_q == LAST_IDX);
      ST_GAP:   in_ready = (gap_q == GAP_LAST);
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    serial_out_d   = IDLE_LEVEL;
    serial_valid_d = 1'b0;
    word_start_d   = 1'b0;
`ifdef SER_PARITY_EN
    parity_d       = parity_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d          = idx_q + IDX_ONE;
          serial_valid_d = 1'b1;
`ifdef SER_PARITY_EN
          if (idx_q == DATA_LAST) begin
            serial_out_d = parity_q;
          end else begin
            serial_out_d = next_bit;
            shreg_d      = next_shreg;
          end
`else
          serial_out_d = next_bit;
          shreg_d      = next_shreg;
`endif
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: ;
    endcase
    // in_ready is only high where an accept legitimately starts a new word.
    if (accept) begin
      state_d        = ST_SHIFT;
      idx_d          = '0;
      gap_d          = '0;
      shreg_d        = load_shreg;
      serial_out_d   = first_bit;
      serial_valid_d = 1'b1;
      word_start_d   = 1'b1;
`ifdef SER_PARITY_EN
      parity_d       = ^in_data;
`endif
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      serial_out_q   <= IDLE_LEVEL;
      serial_valid_q <= 1'b0;
      word_start_q   <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      word_start_q   <= word_start_d;
      busy_q         <= busy_d;
`ifdef SER_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign word_start   = word_start_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bit_serializer
// Purpose  : Testbench for seq_bit_serializer in two parameter configurations.
// Revision : 1.0
// ============================================================================
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int ITERS = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit done[2];

  task automatic check(input int g, input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL i%0d_%s: got %b expected %b at cycle %0d", g, name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit MSBF = (g == 0);
    localparam bit IDL  = (g == 1);
    localparam int GAP  = (g == 0) ? 0 : 2;

    logic         reset, in_valid, in_ready, serial_out, serial_valid, word_start, busy;
    logic [W-1:0] in_data;
    logic [1:0]   exp_q[$];
    logic [W-1:0] dir_q[$];
    int           last_acc, free_at, rst_at;
    bit           flush, started;

    seq_bit_serializer #(
      .WIDTH(W), .MSB_FIRST(MSBF), .IDLE_LEVEL(IDL), .GAP_CYCLES(GAP)
    ) u_dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .serial_out(serial_out), .serial_valid(serial_valid),
      .word_start(word_start), .busy(busy)
    );

    // Expected stream entries are {word_start, bit}.
    function automatic void push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++)
        exp_q.push_back({(i == 0), (MSBF ? w[W-1-i] : w[i])});
`ifdef SER_PARITY_EN
      exp_q.push_back({1'b0, ^w});
`endif
    endfunction

    initial begin
      logic acc;
      logic exp_ready;
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      last_acc = -1000; free_at = 0; rst_at = -1; flush = 0; started = 0;
      if (g == 0) dir_q = '{8'hB4, 8'hA5, 8'h3C, 8'h07, 8'h03, 8'hFF};
      else        dir_q = '{8'h01, 8'h80, 8'hFF};
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      in_valid = 1'b1;
      in_data  = dir_q[0];
      started  = 1;
      for (int it = 0; it < ITERS + 20; it++) begin
        @(negedge clk);
        exp_ready = (cyc >= free_at);
        check(g, "in_ready", in_ready, exp_ready);
        check(g, "serial_valid", serial_valid, (cyc > last_acc) && (cyc <= last_acc + NB));
        check(g, "busy", busy, (cyc > last_acc) && (cyc <= last_acc + NB + GAP));
        acc = !reset && in_valid && exp_ready;
        if (acc) begin
          push_word(in_data);
          if (dir_q.size() > 0 && in_data == 8'hFF) rst_at = cyc + 4;
          last_acc = cyc;
          free_at  = cyc + NB + GAP;
        end
        if (reset) begin
          flush    = 1;
          last_acc = -1000;
          free_at  = 0;
        end
        @(posedge clk);
        if (flush) begin
          exp_q.delete();
          flush = 0;
        end
        #1;
        if (acc && dir_q.size() > 0) void'(dir_q.pop_front());
        if (it >= ITERS) begin
          reset = 1'b0; in_valid = 1'b0;
        end else if (dir_q.size() > 0) begin
          reset = (cyc == rst_at); in_valid = 1'b1; in_data = dir_q[0];
        end else begin
          reset    = (cyc == rst_at) || ($urandom_range(0, 149) == 0);
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = W'($urandom);
        end
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL i%0d_drain: %0d bits never emitted, expected 0", g, exp_q.size());
      end
      done[g] = 1;
    end

    initial begin
      logic [1:0] e;
      wait (started);
      forever begin
        @(negedge clk);
        if (serial_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL i%0d_extra_bit: got serial_valid=1 expected 0 at cycle %0d", g, cyc);
          end else begin
            e = exp_q.pop_front();
            check(g, "serial_out", serial_out, e[0]);
            check(g, "word_start", word_start, e[1]);
          end
        end else begin
          check(g, "idle_level", serial_out, IDL);
          check(g, "idle_word_start", word_start, 1'b0);
        end
      end
    end
  end

  initial begin
    for (int t = 0; t < 60000 && !(done[0] && done[1]); t++) @(posedge clk);
    if (!(done[0] && done[1])) begin
      total++; bad++;
      $display("FAIL timeout: got done=%0d%0d expected 11", done[0], done[1]);
    end
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-in/serial-out stage directly upstream of the serial Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits one bit per clk on serial_out, which drives the detector's x input.
- The detector samples x every cycle, so serial_out always carries a defined level: data bits while streaming, IDLE_LEVEL otherwise.

Parameters:
WIDTH, 8, data word width in bits (>=2)
MSB_FIRST, 1, 1 = in_data[WIDTH-1] sent first, 0 = in_data[0] sent first
IDLE_LEVEL, 0, level driven on serial_out when no bit is being sent
GAP_CYCLES, 0, idle-level cycles inserted between consecutive words (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  parallel word; sampled only on handshake
in_valid  input  1  upstream word available
in_ready  output  1  serializer can accept a word this cycle
serial_out  output  1  serial bit stream to detector x input
serial_valid  output  1  high while serial_out carries a data (or parity) bit
word_start  output  1  one-cycle pulse coincident with first bit of each word
busy  output  1  high when state != IDLE

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Registered outputs: serial_out, serial_valid, word_start, busy.
- in_ready is combinational from state and counters only. It never depends on in_valid.
- States and transitions:
  - IDLE: in_ready=1. On accept (in_valid && in_ready) -> SHIFT.
  - SHIFT: one bit per cycle, bit index 0..N-1, where N=WIDTH (+1 with parity). On the last bit:
    - GAP_CYCLES>0 -> GAP.
    - else if a word is accepted this cycle -> SHIFT at index 0.
    - else -> IDLE.
  - GAP: counts GAP_CYCLES cycles, serial_out=IDLE_LEVEL, serial_valid=0. On the last gap cycle: accept -> SHIFT, else -> IDLE.
- in_ready=1 in these cycles only:
  - IDLE;
  - the last-bit cycle of SHIFT when GAP_CYCLES==0;
  - the last GAP cycle.
- Accepting a word:
  - in_data is captured into the shift register on the accept edge.
  - The first bit appears on serial_out in the next cycle (latency 1).
  - word_start=1 in that cycle only.
  - When GAP_CYCLES==0, back-to-back words stream with zero bubbles.
- Bit order: MSB_FIRST selects shift direction. The other bits are never reordered.
- Bit counter width is $clog2(WIDTH+2). The counter never wraps past N-1.
- After the last bit with no new word: serial_out returns to IDLE_LEVEL and serial_valid=0 in the following cycle.
- in_data/in_valid changes without an accept are ignored. A held in_valid with no ready does not corrupt the shift register.
- Reset values:
  - state=IDLE, shift register=0, counters=0.
  - serial_out=IDLE_LEVEL, serial_valid=0, word_start=0, busy=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-word: the word is aborted and its remaining bits are never emitted. The outputs take reset values on the next edge.
- Reset and in_valid together: reset wins and no word is accepted.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is sent: the even-parity bit (XOR of the captured word).
  - serial_valid=1 and N=WIDTH+1.
  - in_ready/last-bit rules apply to the parity cycle instead of the last data bit.
- Undefined: no parity logic, N=WIDTH.

Test Plan:
1. Reset for 2 cycles, then release -> serial_out=0, serial_valid=0, word_start=0, busy=0, in_ready=1.
2. Single push of 8'b1011_0100 (MSB_FIRST=1) -> cycles 1..8 after accept give serial_out 1,0,1,1,0,1,0,0; serial_valid=1 for exactly 8 cycles; word_start only in cycle 1; serial_out=0 in cycle 9.
3. in_valid held with 8'hA5 then 8'h3C, GAP_CYCLES=0 -> 16 contiguous valid bits 10100101_00111100; in_ready high only in the accept cycle and the bit-8 cycle; two word_start pulses 8 cycles apart.
4. MSB_FIRST=0, GAP_CYCLES=2, words 8'h01 then 8'h80 -> first word gives 1,0,0,0,0,0,0,0; then 2 cycles serial_valid=0 at IDLE_LEVEL; second word gives 0,0,0,0,0,0,0,1.
5. Reset asserted during the 4th bit of 8'hFF -> next cycle serial_out=IDLE_LEVEL, serial_valid=0, in_ready=1; the remaining bits never appear.
6. SER_PARITY_EN defined, push 8'h07 then 8'h03 -> bit 9 of each word is 1 and 0 respectively; 9 valid cycles per word; no bubble between the words.
